// File: rtl/cpu_0_mul_pkg.sv
// Shared constants, opcode and state encodings for the cpu_0 sequenced multiplier.
package cpu_0_mul_pkg;
    localparam int DATA_W = 32;
    localparam int PP_W   = 16;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULXUU = 2'b01,
        OP_MULXSU = 2'b10,
        OP_MULXSS = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        CORR,
        DONE
    } state_e;

    // Bit offset of the partial product issued in step k (lo*lo, hi*lo, lo*hi, hi*hi).
    function automatic logic [6:0] pp_shift(input logic [1:0] k);
        case (k)
            2'd0:    return 7'd0;
            2'd3:    return 7'd32;
            default: return 7'd16;
        endcase
    endfunction
endpackage

// File: rtl/cpu_0_mul_pp16.sv
// 16x16 unsigned multiplier with one output register; maps onto a hard multiplier block.
module cpu_0_mul_pp16 (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] p
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) p <= '0;
        else       p <= 32'(a) * 32'(b);
    end
endmodule

// File: rtl/cpu_0_mul_seq.sv
// Sequenced 32x32 multiply: four 16x16 partial products accumulated into 64 bits.
// Optional CPU_0_MUL_SEQ_EARLY_LO_EN skips the hi*hi product for MUL (low word only).
module cpu_0_mul_seq #(
    parameter int DATA_W = 32,
    parameter int PP_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    input  logic [1:0]        op,
    output logic              result_valid,
    input  logic              result_ready,
    output logic [DATA_W-1:0] result,
    output logic              busy
);
    import cpu_0_mul_pkg::*;

    state_e                state;
    op_e                   op_q;
    logic [DATA_W-1:0]     a_q, b_q;
    logic [1:0]            k, add_k;
    logic                  add_vld;
    logic [2*DATA_W-1:0]   acc, acc_nxt, addend;
    logic [2*PP_W-1:0]     pp;
    logic [PP_W-1:0]       pa, pb;
    logic [DATA_W-1:0]     corr;
    logic                  issue_last;

    cpu_0_mul_pp16 u_pp (
        .clk   (clk),
        .reset (reset),
        .a     (pa),
        .b     (pb),
        .p     (pp)
    );

    // k[0] picks the A half, k[1] the B half; products land one cycle later.
    always_comb begin
        pa      = k[0] ? a_q[DATA_W-1:PP_W] : a_q[PP_W-1:0];
        pb      = k[1] ? b_q[DATA_W-1:PP_W] : b_q[PP_W-1:0];
        addend  = {{(2*DATA_W-2*PP_W){1'b0}}, pp} << pp_shift(add_k);
        acc_nxt = add_vld ? acc + addend : acc;
    end

    // Signed fix-up of the unsigned high word: subtract the other operand per negative signed input.
    always_comb begin
        corr = '0;
        if ((op_q == OP_MULXSU || op_q == OP_MULXSS) && a_q[DATA_W-1])
            corr = b_q;
        if (op_q == OP_MULXSS && b_q[DATA_W-1])
            corr = corr + a_q;
    end

`ifdef CPU_0_MUL_SEQ_EARLY_LO_EN
    assign issue_last = (k == 2'd3) || (op_q == OP_MUL && k == 2'd2);
`else
    assign issue_last = (k == 2'd3);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            op_q         <= OP_MUL;
            a_q          <= '0;
            b_q          <= '0;
            k            <= '0;
            add_k        <= '0;
            add_vld      <= 1'b0;
            acc          <= '0;
            start_ready  <= 1'b1;
            result_valid <= 1'b0;
            result       <= '0;
            busy         <= 1'b0;
        end else begin
            acc     <= acc_nxt;
            add_vld <= (state == ISSUE);
            add_k   <= k;
            case (state)
                IDLE: if (start_valid && start_ready) begin
                    a_q         <= src1;
                    b_q         <= src2;
                    op_q        <= op_e'(op);
                    acc         <= '0;
                    k           <= '0;
                    start_ready <= 1'b0;
                    busy        <= 1'b1;
                    state       <= ISSUE;
                end
                ISSUE: begin
                    k <= k + 2'd1;
                    if (issue_last) state <= DRAIN;
                end
                DRAIN: begin
                    if (op_q == OP_MUL) begin
                        result       <= acc_nxt[DATA_W-1:0];
                        result_valid <= 1'b1;
                        state        <= DONE;
                    end else begin
                        state <= CORR;
                    end
                end
                CORR: begin
                    result       <= acc[2*DATA_W-1:DATA_W] - corr;
                    result_valid <= 1'b1;
                    state        <= DONE;
                end
                DONE: if (result_ready) begin
                    result_valid <= 1'b0;
                    start_ready  <= 1'b1;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_0_mul_seq.sv
// Self-checking bench for cpu_0_mul_seq against a 64-bit arithmetic reference.
module tb_cpu_0_mul_seq;
    logic        clk = 1'b0;
    logic        reset;
    logic        start_valid;
    logic        start_ready;
    logic [31:0] src1, src2;
    logic [1:0]  op;
    logic        result_valid;
    logic        result_ready;
    logic [31:0] result;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

`ifdef CPU_0_MUL_SEQ_EARLY_LO_EN
    localparam int MUL_LAT = 4;
`else
    localparam int MUL_LAT = 5;
`endif

    cpu_0_mul_seq dut (
        .clk          (clk),
        .reset        (reset),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .src1         (src1),
        .src2         (src2),
        .op           (op),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result       (result),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] u;
        longint      sa, sb, ub, p;
        u  = {32'b0, a} * {32'b0, b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        case (o)
            2'b00:   return u[31:0];
            2'b01:   return u[63:32];
            2'b10:   begin p = sa * ub; return p[63:32]; end
            default: begin p = sa * sb; return p[63:32]; end
        endcase
    endfunction

    function automatic int exp_lat(input logic [1:0] o);
        return (o == 2'b00) ? MUL_LAT : 6;
    endfunction

    // Present a request for the coming edge, then scramble inputs once accepted.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start_valid = 1'b1; op = o; src1 = a; src2 = b;
        @(posedge clk); #1;
        start_valid = 1'b0; src1 = $urandom; src2 = $urandom; op = 2'($urandom);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!result_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!result_valid) begin
            miscompares++;
            $display("FAIL wait_valid: result_valid not seen after %0d edges", n);
        end
    endtask

    task automatic finish_hs(input string name);
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
        vectors++;
        if ({start_ready, result_valid, busy} !== 3'b100) begin
            miscompares++;
            $display("FAIL %s_hs: ready/valid/busy=%b expected 100", name, {start_ready, result_valid, busy});
        end
    endtask

    task automatic run_check(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] lit, input logic use_lit, input string name);
        int n;
        logic [31:0] exp;
        exp = use_lit ? lit : ref_mul(o, a, b);
        issue(o, a, b);
        wait_valid(n);
        vectors++;
        if (n !== exp_lat(o)) begin
            miscompares++;
            $display("FAIL %s_lat: got %0d edges expected %0d", name, n, exp_lat(o));
        end
        vectors++;
        if (result !== exp) begin
            miscompares++;
            $display("FAIL %s: op=%0d a=%h b=%h result=%h expected %h", name, o, a, b, result, exp);
        end
        finish_hs(name);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({start_ready, result_valid, busy} !== 3'b100 || result !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_hold: rdy/vld/busy=%b result=%h expected 100/0", {start_ready, result_valid, busy}, result);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if ({start_ready, result_valid, busy} !== 3'b100 || result !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_idle: rdy/vld/busy=%b result=%h expected 100/0", {start_ready, result_valid, busy}, result);
        end
    endtask

    task automatic test_directed();
        run_check(2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 1'b1, "mulxuu_unit");
        run_check(2'b00, 32'h0001_2345, 32'h0000_0010, 32'h0012_3450, 1'b1, "mul_basic");
        run_check(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, "ones_uu");
        run_check(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "ones_su");
        run_check(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, "ones_ss");
        run_check(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, "ones_mul");
    endtask

    task automatic test_backpressure();
        int n;
        int bad = 0;
        issue(2'b01, 32'h0001_0000, 32'h0001_0000);
        wait_valid(n);
        for (int i = 0; i < 10; i++) begin
            start_valid = (i == 5);
            src1 = $urandom; src2 = $urandom;
            if (!result_valid || result !== 32'h1 || start_ready || !busy) bad++;
            @(posedge clk); #1;
        end
        start_valid = 1'b0;
        vectors++;
        if (bad != 0 || !result_valid || result !== 32'h1) begin
            miscompares++;
            $display("FAIL backpressure_hold: %0d unstable cycles, vld=%b result=%h expected 1/00000001", bad, result_valid, result);
        end
        finish_hs("backpressure");
        vectors++;
        if (result !== 32'h1) begin
            miscompares++;
            $display("FAIL backpressure_keep: result=%h expected 00000001", result);
        end
        @(posedge clk); #1;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL backpressure_ignored: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        issue(2'b01, 32'h0000_0005, 32'h0000_0007);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        vectors++;
        if ({start_ready, result_valid, busy} !== 3'b100 || result !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_mid: rdy/vld/busy=%b result=%h expected 100/0", {start_ready, result_valid, busy}, result);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (result_valid || busy) pulses++;
            @(posedge clk); #1;
        end
        vectors++;
        if (pulses != 0) begin
            miscompares++;
            $display("FAIL reset_mid_quiet: %0d cycles with valid/busy, expected 0", pulses);
        end
        run_check(2'b01, 32'h0000_0002, 32'h0000_0003, 32'h0000_0000, 1'b1, "after_reset");
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_q[$];
        int accepts = 0, hs = 0, cyc = 0, overlap = 0, wrong = 0;
        logic [31:0] exp;
        result_ready = 1'b1;
        start_valid  = 1'b1;
        op   = 2'b00;
        src1 = $urandom; src2 = $urandom;
        while (hs < 8 && cyc < 400) begin
            if (start_ready && result_valid) overlap++;
            if (start_ready && start_valid) begin
                exp_q.push_back(ref_mul(op, src1, src2));
                accepts++;
            end
            if (result_valid && result_ready) begin
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : ~result;
                if (result !== exp) begin
                    wrong++;
                    $display("FAIL b2b_result_%0d: result=%h expected %h", hs, result, exp);
                end
                hs++;
            end
            @(posedge clk); #1;
            cyc++;
            op   = 2'(accepts);
            src1 = $urandom; src2 = $urandom;
        end
        start_valid  = 1'b0;
        result_ready = 1'b0;
        vectors++;
        if (hs != 8) begin
            miscompares++;
            $display("FAIL b2b_timeout: %0d handshakes in %0d cycles, expected 8", hs, cyc);
        end
        vectors++;
        miscompares += wrong;
        vectors++;
        if (accepts != hs || overlap != 0) begin
            miscompares++;
            $display("FAIL b2b_accepts: accepts=%0d handshakes=%0d overlap=%0d expected equal/0", accepts, hs, overlap);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 6 == 0) a[31] = 1'b1;
            if (i % 4 == 1) b = 32'h8000_0000;
            run_check(2'(i), a, b, 32'h0, 1'b0, "random");
        end
    endtask

    initial begin
        reset = 1'b1; start_valid = 1'b0; result_ready = 1'b0;
        src1 = '0; src2 = '0; op = '0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
